// File: rtl/ahb_lite_mst_ctrl.sv
// Purpose: single-master AHB-lite initiator, valid/ready commands -> pipelined SINGLE transfers.
// Latency: accept at edge N -> NONSEQ in N+1, data phase N+2, rsp_vld N+3; +1 cycle per wait state.
// Backpressure: cmd_rdy low while the address phase stalls, during ERROR retry, and for a
//   misaligned command until the pipe is empty; responses are never back-pressured.
// Ports: pll_core_cpuclk/pad_cpu_rst_b clock and async active-low reset; cmd_* command stream;
//   rsp_* one-cycle in-order response pulse; mst_yy_* AHB-lite master outputs; mmc_mst_* slave returns.
module ahb_lite_mst_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  pll_core_cpuclk,
  input  logic                  pad_cpu_rst_b,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic                  cmd_write,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_vld,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mst_yy_haddr,
  output logic [1:0]            mst_yy_htrans,
  output logic [2:0]            mst_yy_hsize,
  output logic                  mst_yy_hwrite,
  output logic [31:0]           mst_yy_hwdata,
  input  logic [31:0]           mmc_mst_hrdata,
  input  logic                  mmc_mst_hready,
  input  logic [1:0]            mmc_mst_hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // address-phase register
  logic                  ap_vld_q, ap_vld_d;
  logic [ADDR_WIDTH-1:0] ap_addr_q, ap_addr_d;
  logic [2:0]            ap_size_q, ap_size_d;
  logic                  ap_write_q, ap_write_d;
  logic [31:0]           ap_wdata_q, ap_wdata_d;
  // set between ERROR cycle 1 and 2: the retained AP command is masked to IDLE
  logic                  retry_q, retry_d;
  // data-phase register
  logic                  dp_vld_q, dp_vld_d;
  logic                  dp_write_q, dp_write_d;
  logic [31:0]           dp_wdata_q, dp_wdata_d;
  // response register
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic err1;
  logic cmd_mis;
  logic cmd_acc;
  logic ap_adv;
  logic dp_done;
  logic hresp_unused;

  assign hresp_unused = mmc_mst_hresp[1];

  assign err1    = dp_vld_q && mmc_mst_hresp[0] && !mmc_mst_hready;
  assign cmd_mis = (cmd_size > 3'd2)
                || ((cmd_size == 3'd1) && cmd_addr[0])
                || ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));

  // A misaligned command never reaches the bus; holding it until AP and DP are
  // empty is what keeps its local error response in command order.
  assign cmd_rdy = cmd_mis ? (!retry_q && !ap_vld_q && !dp_vld_q)
                           : (!retry_q && (!ap_vld_q || (mmc_mst_hready && !err1)));

  assign cmd_acc = cmd_vld && cmd_rdy;
  assign ap_adv  = ap_vld_q && !retry_q && mmc_mst_hready;
  assign dp_done = dp_vld_q && mmc_mst_hready;

  always_comb begin
    ap_vld_d   = ap_vld_q;
    ap_addr_d  = ap_addr_q;
    ap_size_d  = ap_size_q;
    ap_write_d = ap_write_q;
    ap_wdata_d = ap_wdata_q;
    retry_d    = retry_q;
    if (ap_adv) begin
      ap_vld_d = 1'b0;
    end
    if (cmd_acc && !cmd_mis) begin
      ap_vld_d   = 1'b1;
      ap_addr_d  = cmd_addr;
      ap_size_d  = cmd_size;
      ap_write_d = cmd_write;
      ap_wdata_d = cmd_wdata;
    end
    // ERROR cycle 1 with a command waiting: drop it to IDLE for cycle 2,
    // then re-drive it once the second ERROR cycle has completed.
    if (err1 && ap_vld_q) begin
      retry_d = 1'b1;
    end else if (retry_q && mmc_mst_hready) begin
      retry_d = 1'b0;
    end
  end

  always_comb begin
    dp_vld_d   = dp_vld_q;
    dp_write_d = dp_write_q;
    dp_wdata_d = dp_wdata_q;
    if (mmc_mst_hready) begin
      dp_vld_d = ap_adv;
      if (ap_adv) begin
        dp_write_d = ap_write_q;
        dp_wdata_d = ap_wdata_q;
      end
    end
  end

  always_comb begin
    rsp_vld_d   = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    if (dp_done) begin
      rsp_vld_d = 1'b1;
      rsp_err_d = mmc_mst_hresp[0];
      if (!dp_write_q && !mmc_mst_hresp[0]) begin
        rsp_rdata_d = mmc_mst_hrdata;
      end
    end else if (cmd_acc && cmd_mis) begin
      rsp_vld_d = 1'b1;
      rsp_err_d = 1'b1;
    end
  end

  always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      ap_vld_q    <= 1'b0;
      ap_addr_q   <= '0;
      ap_size_q   <= 3'd0;
      ap_write_q  <= 1'b0;
      ap_wdata_q  <= 32'h0;
      retry_q     <= 1'b0;
      dp_vld_q    <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_wdata_q  <= 32'h0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      ap_vld_q    <= ap_vld_d;
      ap_addr_q   <= ap_addr_d;
      ap_size_q   <= ap_size_d;
      ap_write_q  <= ap_write_d;
      ap_wdata_q  <= ap_wdata_d;
      retry_q     <= retry_d;
      dp_vld_q    <= dp_vld_d;
      dp_write_q  <= dp_write_d;
      dp_wdata_q  <= dp_wdata_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign mst_yy_htrans = (ap_vld_q && !retry_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign mst_yy_haddr  = ap_addr_q;
  assign mst_yy_hsize  = ap_size_q;
  assign mst_yy_hwrite = ap_write_q;
  assign mst_yy_hwdata = dp_wdata_q;
  assign rsp_vld       = rsp_vld_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;

endmodule

// File: doc/ahb_lite_mst_ctrl.md
# ahb_lite_mst_ctrl

Single-master AHB-lite initiator that turns a simple valid/ready command stream into pipelined AHB-lite SINGLE transfers. It is the initiator counterpart to the AHB-lite memory responders on the instruction/data buses. Typical uses are a bench traffic source, a boot loader or a DMA front end driving those responders. It overlaps one address phase with one data phase, honours HREADY wait states, handles the two-cycle ERROR response and returns one response per command, in order.

## Interface
- ADDR_WIDTH, 32, width of cmd_addr/mst_yy_haddr; data width fixed at 32.
- pll_core_cpuclk  in  1  sole clock; all state on rising edge.
- pad_cpu_rst_b  in  1  reset, asynchronous, active-low.
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  command accepted when cmd_vld && cmd_rdy at a rising edge.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_size  in  3  0=byte, 1=half, 2=word; other values are illegal.
- cmd_write  in  1  1=write, 0=read.
- cmd_wdata  in  32  write data, lane-positioned per AHB (caller aligns).
- rsp_vld  out  1  one-cycle response pulse; no back-pressure.
- rsp_rdata  out  32  HRDATA for reads, 0 for writes and errors.
- rsp_err  out  1  1 = ERROR response, or local misalignment error.
- mst_yy_haddr  out  ADDR_WIDTH; mst_yy_htrans  out  2 (IDLE=00, NONSEQ=10 only); mst_yy_hsize  out  3; mst_yy_hwrite  out  1; mst_yy_hwdata  out  32.
- mmc_mst_hrdata  in  32; mmc_mst_hready  in  1; mmc_mst_hresp  in  2 (bit0=ERROR).

## Operation
- Address-phase register (AP) drives haddr/hsize/hwrite/htrans. AP is NONSEQ when it holds a command, otherwise IDLE. Data-phase register (DP) holds valid, write and wdata for the transfer whose address phase has completed.
- Advance: on each edge with hready=1, AP content moves to DP. DP.wdata is captured from the AP command, and mst_yy_hwdata = DP.wdata, held stable across wait states.
- cmd_rdy = !retry && (AP empty || (hready && !err1)). err1 = DP valid && hresp[0] && !hready.
- Accepting a command while AP advances is allowed, giving 1 transfer/cycle throughput.
- Completion: DP valid && hready=1 at an edge. On the next cycle rsp_vld=1 and rsp_err=hresp[0]. rsp_rdata = hrdata when the command is a read with no error, otherwise 0.
- ERROR cycle 1 (err1): if AP holds NONSEQ, the next cycle drives htrans=IDLE. The AP command is kept and retry is set. ERROR cycle 2 (hready=1) completes DP with the error, and the IDLE address phase produces no DP. The following cycle re-drives the retained command as NONSEQ and retry clears.
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size>2. cmd_rdy for such a command is only asserted when AP and DP are both empty. On accept, no bus transfer occurs, and rsp_vld=1, rsp_err=1, rsp_rdata=0 appear the next cycle. Ordering of responses is preserved.
- Responses are always in command order. Only one transfer is ever in the data phase.

## Timing
- Reset values: htrans=IDLE, haddr=0, hsize=0, hwrite=0, hwdata=0, rsp_vld=0, rsp_rdata=0, rsp_err=0; cmd_rdy=1 after reset release.
- Accept at edge N: NONSEQ is visible in cycle N+1. With zero waits, the data phase is in N+2 and rsp_vld is in N+3. Each wait state adds 1 cycle.
- While hready=0: AP and DP outputs hold; only the err1 IDLE substitution changes htrans.
- Reset asserted mid-transfer: all registers clear immediately, in-flight commands are dropped and no response is issued.
- Simultaneous accept and completion in the same edge is legal. rsp_vld for the old command and NONSEQ for the new one appear together.

## Test plan
- Reset: hold pad_cpu_rst_b=0 with random inputs -> all outputs at reset values, htrans=00; release -> cmd_rdy=1.
- Single read: word read of 0x100, responder returns 0xDEADBEEF with hready=1 -> NONSEQ at N+1, rsp_vld at N+3, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Back-to-back with waits: write 0x11223344 to 0x200, then read 0x200, with 2 wait states on the write -> hwdata stable for all 3 data cycles, read haddr held during waits, 2 in-order responses, read returns 0x11223344.
- Error with pending command: read 0x300 gets ERROR while a write to 0x304 sits in AP -> htrans=IDLE in ERROR cycle 2, rsp_err=1 for 0x300, 0x304 re-issued as NONSEQ next cycle and completes with rsp_err=0.
- Misaligned: word read at 0x102 behind an outstanding read -> cmd_rdy=0 until the pipeline drains, no bus transfer, then rsp_err=1, rsp_rdata=0.
- Byte/half sizes: writes with size 0 at addr 0x3 and size 1 at addr 0x2 -> hsize/haddr passed unchanged, 1 response each.
